// File: rtl/i2c_dp_pkg.sv
// Shared constants and helpers for the I2C master/slave bit-level datapaths.
package i2c_dp_pkg;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int DEF_DRIVE_OFS = 1;

  // Bit counter must hold 0..bits, the extra value being the ACK slot.
  function automatic int bit_cnt_w(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/i2c_bit_shifter.sv
// Frame bit counter plus MSB-first receive shift register; updates on the cycle after a sample strobe.
// No backpressure: every qualified sample strobe is consumed.
module i2c_bit_shifter
  import i2c_dp_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic                       i2c_core_clock_i,
  input  logic                       reset_bit_n_i,
  input  logic                       clr_i,
  input  logic                       smp_i,
  input  logic                       shift_i,
  input  logic                       sda_i,
  output logic [bit_cnt_w(BITS)-1:0] bit_cnt_o,
  output logic [BITS-1:0]            shift_nxt_o,
  output logic                       ack_bit_o,
  output logic                       last_data_bit_o
);

  localparam int BCW = bit_cnt_w(BITS);

  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BITS-1:0] shift_q, shift_d;

  always_comb begin
    ack_bit_o       = (bit_cnt_q == BCW'(BITS));
    last_data_bit_o = (bit_cnt_q == BCW'(BITS - 1));
    shift_nxt_o     = {shift_q[BITS-2:0], sda_i};

    // The ACK slot sample wraps straight back to bit 0 of the next frame.
    bit_cnt_d = bit_cnt_q;
    if (clr_i) begin
      bit_cnt_d = '0;
    end else if (smp_i) begin
      bit_cnt_d = ack_bit_o ? '0 : bit_cnt_q + BCW'(1);
    end

    shift_d = shift_q;
    if (shift_i) begin
      shift_d = shift_nxt_o;
    end
  end

  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
    if (!reset_bit_n_i) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  assign bit_cnt_o = bit_cnt_q;

endmodule

// File: rtl/i2c_burst_datapath.sv
// I2C master bit datapath: SDA drive, RX/TX byte handshakes, burst/ACK tracking, arbitration loss.
// All outputs registered one cycle after the qualifying phase strobe/edge count; no backpressure.
module i2c_burst_datapath
  import i2c_dp_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int CNT_W     = 8,
  parameter int LEN_W     = 8,
  parameter int DRIVE_OFS = DEF_DRIVE_OFS,
  parameter bit AUTO_NACK = 1'b1
) (
  input  logic                       i2c_core_clock_i,
  input  logic                       reset_bit_n_i,
  input  logic                       sda_i,
  input  logic                       start_cnt_i,
  input  logic                       repeat_start_cnt_i,
  input  logic                       stop_cnt_i,
  input  logic                       write_addr_cnt_i,
  input  logic                       write_data_cnt_i,
  input  logic                       read_data_cnt_i,
  input  logic                       write_ack_cnt_i,
  input  logic                       read_ack_cnt_i,
  input  logic [CNT_W-1:0]           counter_detect_edge_i,
  input  logic [CNT_W-1:0]           prescaler_i,
  input  logic [CNT_W-1:0]           counter_state_done_time_repeat_start_i,
  input  logic [BITS-1:0]            addr_rw_i,
  input  logic [BITS-1:0]            tx_data_i,
  input  logic                       ack_bit_i,
  input  logic [LEN_W-1:0]           burst_len_i,
  input  logic                       arb_clr_i,
  output logic                       sda_o,
  output logic [BITS-1:0]            rx_data_o,
  output logic                       rx_valid_o,
  output logic                       tx_req_o,
  output logic [bit_cnt_w(BITS)-1:0] bit_cnt_o,
  output logic [LEN_W-1:0]           byte_cnt_o,
  output logic                       burst_last_o,
  output logic                       ack_rcvd_o,
  output logic                       nack_o,
  output logic                       arb_lost_o
);

  localparam logic [CNT_W-1:0] DRV_PT = CNT_W'(DRIVE_OFS);
  localparam logic [CNT_W-1:0] ACK_PT = CNT_W'(DRIVE_OFS + 1);

  logic win_start, win_rs, win_stop, win_wack, win_rack, win_rdat, win_wadr, win_wdat;
  logic ctrl_phase, data_win, cnt_clr;
  logic drv_evt, smp_evt, ack_evt, smp_data, ack_smp;
  logic rs_release, burst_last, frame_ack, last_data_bit;
  logic [CNT_W+1:0] rs_limit;
  logic [LEN_W:0]   done_plus1, len_eff;
  logic [BITS-1:0]  tx_frame, tx_shifted, shift_nxt;

  logic             sda_q, sda_d;
  logic [BITS-1:0]  rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tx_req_q, tx_req_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             ack_rcvd_q, ack_rcvd_d;
  logic             nack_q, nack_d;
  logic             arb_lost_q, arb_lost_d;
  logic             wr_frame_q, wr_frame_d;

  // Exactly one phase wins per cycle, so only that phase moves any state.
  always_comb begin
    win_start  = start_cnt_i;
    win_rs     = !start_cnt_i && repeat_start_cnt_i;
    win_stop   = !start_cnt_i && !repeat_start_cnt_i && stop_cnt_i;
    ctrl_phase = start_cnt_i || repeat_start_cnt_i || stop_cnt_i;
    win_wack   = !ctrl_phase && write_ack_cnt_i;
    win_rack   = !ctrl_phase && !write_ack_cnt_i && read_ack_cnt_i;
    win_rdat   = !ctrl_phase && !write_ack_cnt_i && !read_ack_cnt_i && read_data_cnt_i;
    win_wadr   = !ctrl_phase && !write_ack_cnt_i && !read_ack_cnt_i && !read_data_cnt_i
                 && write_addr_cnt_i;
    win_wdat   = !ctrl_phase && !write_ack_cnt_i && !read_ack_cnt_i && !read_data_cnt_i
                 && !write_addr_cnt_i && write_data_cnt_i;
    data_win   = win_wack || win_rack || win_rdat || win_wadr || win_wdat;
    cnt_clr    = win_start || win_rs;
  end

  assign drv_evt  = (counter_detect_edge_i == DRV_PT);
  assign smp_evt  = (counter_detect_edge_i == prescaler_i);
  assign ack_evt  = (counter_detect_edge_i == ACK_PT);
  assign smp_data = data_win && smp_evt;
  assign ack_smp  = smp_data && frame_ack;

  // Widened by two bits so 2*prescaler+1 never wraps.
  assign rs_limit   = ({2'b00, prescaler_i} << 1) + (CNT_W+2)'(1);
  assign rs_release = ({2'b00, counter_state_done_time_repeat_start_i} < rs_limit);

  assign done_plus1 = {1'b0, byte_cnt_q} + (LEN_W+1)'(1);
  assign len_eff    = (burst_len_i == '0) ? (LEN_W+1)'(1) : {1'b0, burst_len_i};
  assign burst_last = (done_plus1 >= len_eff);

  assign tx_frame   = win_wadr ? addr_rw_i : tx_data_i;
  assign tx_shifted = tx_frame << bit_cnt_o;

  i2c_bit_shifter #(
    .BITS (BITS)
  ) u_bit_shifter (
    .i2c_core_clock_i (i2c_core_clock_i),
    .reset_bit_n_i    (reset_bit_n_i),
    .clr_i            (cnt_clr),
    .smp_i            (smp_data),
    .shift_i          (win_rdat && smp_evt),
    .sda_i            (sda_i),
    .bit_cnt_o        (bit_cnt_o),
    .shift_nxt_o      (shift_nxt),
    .ack_bit_o        (frame_ack),
    .last_data_bit_o  (last_data_bit)
  );

  always_comb begin
    sda_d = sda_q;
    if (win_start) begin
      sda_d = 1'b0;
    end else if (win_rs) begin
      sda_d = rs_release;
    end else if (win_stop) begin
      if (drv_evt) begin
        sda_d = 1'b0;
      end else if (smp_evt) begin
        sda_d = 1'b1;
      end
    end else if (win_wack) begin
      if (ack_evt) begin
        sda_d = (AUTO_NACK && burst_last) ? NACK : ack_bit_i;
      end
    end else if (win_rack || win_rdat) begin
      sda_d = 1'b1;
    end else if ((win_wadr || win_wdat) && drv_evt && !frame_ack) begin
      sda_d = tx_shifted[BITS-1];
    end
    // A master that lost the bus must stay off it until a fresh START.
    if (arb_lost_q && !win_start) begin
      sda_d = 1'b1;
    end

    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (win_rdat && smp_evt && last_data_bit) begin
      rx_data_d  = shift_nxt;
      rx_valid_d = 1'b1;
    end

    ack_rcvd_d = ack_rcvd_q;
    nack_d     = 1'b0;
    if (win_rack && smp_evt && frame_ack) begin
      ack_rcvd_d = sda_i;
      nack_d     = sda_i;
    end

    byte_cnt_d = byte_cnt_q;
    if (cnt_clr) begin
      byte_cnt_d = '0;
    end else if (ack_smp && (byte_cnt_q != '1)) begin
      byte_cnt_d = byte_cnt_q + LEN_W'(1);
    end

    // The ACK slot runs under an ACK phase, so remember that the frame carried TX data.
    wr_frame_d = wr_frame_q;
    if (cnt_clr || ack_smp) begin
      wr_frame_d = 1'b0;
    end else if (win_wdat && smp_evt) begin
      wr_frame_d = 1'b1;
    end
    tx_req_d = ack_smp && (wr_frame_q || win_wdat);

    arb_lost_d = arb_lost_q;
    if (arb_clr_i || start_cnt_i) begin
      arb_lost_d = 1'b0;
    end else if ((win_wadr || win_wdat) && smp_evt && sda_q && !sda_i) begin
      arb_lost_d = 1'b1;
    end
  end

  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
    if (!reset_bit_n_i) begin
      sda_q      <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      byte_cnt_q <= '0;
      ack_rcvd_q <= 1'b1;
      nack_q     <= 1'b0;
      arb_lost_q <= 1'b0;
      wr_frame_q <= 1'b0;
    end else begin
      sda_q      <= sda_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      byte_cnt_q <= byte_cnt_d;
      ack_rcvd_q <= ack_rcvd_d;
      nack_q     <= nack_d;
      arb_lost_q <= arb_lost_d;
      wr_frame_q <= wr_frame_d;
    end
  end

  assign sda_o        = sda_q;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign tx_req_o     = tx_req_q;
  assign byte_cnt_o   = byte_cnt_q;
  assign burst_last_o = burst_last;
  assign ack_rcvd_o   = ack_rcvd_q;
  assign nack_o       = nack_q;
  assign arb_lost_o   = arb_lost_q;

endmodule

// File: tb/tb_i2c_burst_datapath.sv
// Bench for i2c_burst_datapath: drives controller phases/edge counts, compares against a byte-level model.
module tb_i2c_burst_datapath;
  import i2c_dp_pkg::*;

  localparam int BITS  = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = 8;

  localparam int P_NONE = 0, P_START = 1, P_RS = 2, P_STOP = 3, P_WADR = 4;
  localparam int P_WDAT = 5, P_RDAT = 6, P_WACK = 7, P_RACK = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, sda_in;
  logic             st, rs, sp, wadr, wdat, rdat, wack, rack;
  logic [CNT_W-1:0] cnt_edge, prescaler, rs_timer;
  logic [BITS-1:0]  addr_rw, tx_data;
  logic             ack_bit, arb_clr;
  logic [LEN_W-1:0] burst_len;
  logic             sda_o, rx_valid_o, tx_req_o, burst_last_o, ack_rcvd_o, nack_o, arb_lost_o;
  logic [BITS-1:0]  rx_data_o;
  logic [3:0]       bit_cnt_o;
  logic [LEN_W-1:0] byte_cnt_o;

  i2c_burst_datapath #(
    .BITS(BITS), .CNT_W(CNT_W), .LEN_W(LEN_W), .DRIVE_OFS(1), .AUTO_NACK(1'b1)
  ) dut (
    .i2c_core_clock_i                       (clk),
    .reset_bit_n_i                          (rst_n),
    .sda_i                                  (sda_in),
    .start_cnt_i                            (st),
    .repeat_start_cnt_i                     (rs),
    .stop_cnt_i                             (sp),
    .write_addr_cnt_i                       (wadr),
    .write_data_cnt_i                       (wdat),
    .read_data_cnt_i                        (rdat),
    .write_ack_cnt_i                        (wack),
    .read_ack_cnt_i                         (rack),
    .counter_detect_edge_i                  (cnt_edge),
    .prescaler_i                            (prescaler),
    .counter_state_done_time_repeat_start_i (rs_timer),
    .addr_rw_i                              (addr_rw),
    .tx_data_i                              (tx_data),
    .ack_bit_i                              (ack_bit),
    .burst_len_i                            (burst_len),
    .arb_clr_i                              (arb_clr),
    .sda_o                                  (sda_o),
    .rx_data_o                              (rx_data_o),
    .rx_valid_o                             (rx_valid_o),
    .tx_req_o                               (tx_req_o),
    .bit_cnt_o                              (bit_cnt_o),
    .byte_cnt_o                             (byte_cnt_o),
    .burst_last_o                           (burst_last_o),
    .ack_rcvd_o                             (ack_rcvd_o),
    .nack_o                                 (nack_o),
    .arb_lost_o                             (arb_lost_o)
  );

  int checks = 0;
  int errors = 0;
  int pre = 4;

  // Pulse monitor: logs every received byte and counts handshake pulses.
  logic [7:0] rx_log [64];
  int rx_n = 0;
  int tx_n = 0;
  int nack_n = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid_o) begin
        if (rx_n < 64) rx_log[rx_n] <= rx_data_o;
        rx_n <= rx_n + 1;
      end
      if (tx_req_o) tx_n <= tx_n + 1;
      if (nack_o) nack_n <= nack_n + 1;
    end
  end

  logic [7:0] wdat_tbl [4];
  logic       wack_tbl [4];
  logic [7:0] rdat_tbl [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_phase(input int ph);
    st = (ph == P_START); rs = (ph == P_RS); sp = (ph == P_STOP);
    wadr = (ph == P_WADR); wdat = (ph == P_WDAT); rdat = (ph == P_RDAT);
    wack = (ph == P_WACK); rack = (ph == P_RACK);
  endtask

  task automatic idle(input int n);
    set_phase(P_NONE);
    cnt_edge = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL bit: edge counter sweeps 0..2*pre-1; returns SDA seen after edge counts 0, 1, 2 and at bit end.
  task automatic run_bit(input int ph, input logic sin, output logic v0, output logic vd,
                         output logic va, output logic ve);
    set_phase(ph);
    sda_in = sin;
    v0 = 1'b0; vd = 1'b0; va = 1'b0;
    for (int c = 0; c < 2 * pre; c++) begin
      cnt_edge = CNT_W'(c);
      @(posedge clk);
      #1;
      if (c == 0) v0 = sda_o;
      if (c == 1) vd = sda_o;
      if (c == 2) va = sda_o;
    end
    ve = sda_o;
  endtask

  task automatic do_start();
    logic v0, vd, va, ve;
    run_bit(P_START, 1'b1, v0, vd, va, ve);
    chk("start_sda", ve, 1'b0);
    chk("start_clr", {bit_cnt_o, byte_cnt_o}, 0);
  endtask

  task automatic do_stop();
    logic v0, vd, va, ve;
    run_bit(P_STOP, 1'b1, v0, vd, va, ve);
    chk("stop_drv", vd, 1'b0);
    chk("stop_rel", ve, 1'b1);
  endtask

  // Master-transmitted frame; sda_i mirrors the intended bit except at arb_at where the bus reads 0.
  task automatic wr_frame(input int ph, input logic [7:0] b, input logic sack, input int arb_at,
                          output logic [7:0] obs_drv, output logic [7:0] obs_pre,
                          output logic [7:0] arb_hist);
    logic v0, vd, va, ve;
    for (int i = 0; i < 8; i++) begin
      run_bit(ph, (i == arb_at) ? 1'b0 : b[7-i], v0, vd, va, ve);
      obs_drv[7-i]  = vd;
      obs_pre[7-i]  = v0;
      arb_hist[7-i] = arb_lost_o;
    end
    run_bit(P_RACK, sack, v0, vd, va, ve);
    chk("ack_release", ve, 1'b1);
    chk("ack_rcvd", ack_rcvd_o, sack);
    chk("bit_wrap", bit_cnt_o, 0);
  endtask

  task automatic rd_frame(input logic [7:0] b, output logic [7:0] obs, output logic ackv);
    logic v0, vd, va, ve;
    for (int i = 0; i < 8; i++) begin
      run_bit(P_RDAT, b[7-i], v0, vd, va, ve);
      obs[7-i] = vd & ve;
    end
    run_bit(P_WACK, 1'b1, v0, vd, va, ve);
    ackv = va;
  endtask

  task automatic seq_write(input logic [7:0] addr, input int n);
    int tx0, nk0, exp_nk;
    logic [7:0] od, op, ah;
    addr_rw = addr;
    do_start();
    tx0 = tx_n; nk0 = nack_n; exp_nk = 0;
    wr_frame(P_WADR, addr, ACK, -1, od, op, ah);
    chk("addr_bits", od, addr);
    chk("addr_hold", op[6:0], addr[7:1]);
    chk("no_arb", ah, 0);
    for (int k = 0; k < n; k++) begin
      tx_data = wdat_tbl[k];
      wr_frame(P_WDAT, wdat_tbl[k], wack_tbl[k], -1, od, op, ah);
      chk("data_bits", od, wdat_tbl[k]);
      chk("data_hold", op[6:0], wdat_tbl[k][7:1]);
      if (wack_tbl[k] == NACK) exp_nk++;
    end
    idle(2);
    chk("tx_req_cnt", tx_n - tx0, n);
    chk("nack_cnt", nack_n - nk0, exp_nk);
    chk("byte_cnt", byte_cnt_o, n + 1);
    do_stop();
  endtask

  task automatic seq_read(input int n, input logic ackb, input int len);
    int rx0, eff;
    logic [7:0] obs;
    logic av;
    burst_len = LEN_W'(len);
    ack_bit = ackb;
    eff = (len == 0) ? 1 : len;
    do_start();
    chk("burst_last0", burst_last_o, (eff <= 1));
    rx0 = rx_n;
    for (int j = 0; j < n; j++) begin
      rd_frame(rdat_tbl[j], obs, av);
      chk("rd_release", obs, 8'hFF);
      chk("rd_ack_drv", av, (j + 1 >= eff) ? NACK : ackb);
    end
    idle(2);
    chk("rx_cnt", rx_n - rx0, n);
    for (int j = 0; j < n; j++) chk("rx_byte", rx_log[rx0 + j], rdat_tbl[j]);
    do_stop();
  endtask

  task automatic chk_reset_vals();
    chk("rst_flags", {sda_o, ack_rcvd_o, rx_valid_o, tx_req_o, nack_o, arb_lost_o, burst_last_o},
        7'b1100000);
    chk("rst_rx_data", rx_data_o, 0);
    chk("rst_counts", {bit_cnt_o, byte_cnt_o}, 0);
  endtask

  initial begin
    logic [7:0] od, op, ah;
    logic [13:0] rs_obs, rs_exp;
    logic [9:0] st_obs, st_exp;
    logic v0, vd, va, ve;
    int rx0, n;

    rst_n = 1'b0; sda_in = 1'b1; set_phase(P_NONE);
    cnt_edge = '0; prescaler = CNT_W'(pre); rs_timer = '0;
    addr_rw = '0; tx_data = '0; ack_bit = 1'b0; arb_clr = 1'b0; burst_len = LEN_W'(2);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst_n = 1'b1;
    idle(2);

    // Address 0xA4 then data 0x3C, slave ACKs both.
    wdat_tbl[0] = 8'h3C; wack_tbl[0] = ACK;
    seq_write(8'hA4, 1);

    // Slave NACKs the second data byte.
    wdat_tbl[0] = 8'h96; wack_tbl[0] = ACK;
    wdat_tbl[1] = 8'h0F; wack_tbl[1] = NACK;
    seq_write(8'h54, 2);

    // Read burst of three with auto-NACK on the last byte.
    rdat_tbl[0] = 8'h5A; rdat_tbl[1] = 8'hFF; rdat_tbl[2] = 8'h81;
    seq_read(3, ACK, 3);

    // Reset asserted part-way through bit 4 of a read.
    burst_len = LEN_W'(3);
    do_start();
    for (int i = 0; i < 4; i++) run_bit(P_RDAT, 1'b1, v0, vd, va, ve);
    for (int c = 0; c < 3; c++) begin
      cnt_edge = CNT_W'(c);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    rx0 = rx_n;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) run_bit(P_RDAT, 1'b1, v0, vd, va, ve);
    idle(2);
    chk("no_rx_after_rst", rx_n - rx0, 0);

    // Arbitration lost on address bit 2, then cleared.
    do_start();
    addr_rw = 8'hA4;
    wr_frame(P_WADR, 8'hA4, ACK, 2, od, op, ah);
    chk("arb_hist", ah, 8'h3F);
    chk("arb_first_bits", od[7:5], 3'b101);
    chk("arb_forced_rel", od[4:0], 5'h1F);
    arb_clr = 1'b1;
    @(posedge clk);
    #1;
    arb_clr = 1'b0;
    chk("arb_clr", arb_lost_o, 1'b0);

    // Repeat start and stop timing with prescaler 5.
    pre = 5; prescaler = CNT_W'(pre);
    do_start();
    addr_rw = 8'h50;
    wr_frame(P_WADR, 8'h50, ACK, -1, od, op, ah);
    set_phase(P_RS);
    cnt_edge = '0;
    for (int t = 0; t < 14; t++) begin
      rs_timer = CNT_W'(t);
      @(posedge clk);
      #1;
      rs_obs[t] = sda_o;
      rs_exp[t] = (t < 2 * pre + 1);
    end
    chk("rs_profile", rs_obs, rs_exp);
    chk("rs_clr", {bit_cnt_o, byte_cnt_o}, 0);
    set_phase(P_STOP);
    for (int c = 0; c < 10; c++) begin
      cnt_edge = CNT_W'(c);
      @(posedge clk);
      #1;
      st_obs[c] = sda_o;
      st_exp[c] = (c >= pre);
    end
    chk("stop_profile", st_obs, st_exp);

    // Randomised transactions.
    for (int it = 0; it < 8; it++) begin
      pre = $urandom_range(3, 7);
      prescaler = CNT_W'(pre);
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          wdat_tbl[k] = 8'($urandom);
          wack_tbl[k] = ($urandom_range(0, 3) == 0) ? NACK : ACK;
        end
        seq_write(8'($urandom) & 8'hFE, n);
      end else begin
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) rdat_tbl[k] = 8'($urandom);
        seq_read(n, 1'($urandom), (n == 1 && $urandom_range(0, 1) == 1) ? 0 : n);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_burst_datapath.md
Name: i2c_burst_datapath

Overview:
- Parametrised next-generation I2C master bit-level datapath.
- Sits between the i2c controller FSM (one-hot phase strobes, SCL edge counter) and the SDA pad.
- Adds over the previous datapath:
  - configurable frame width;
  - multi-byte burst counting with automatic NACK on the last read byte;
  - ACK/NACK capture from the slave;
  - arbitration-loss detection;
  - valid/request handshakes for RX/TX bytes.

Parameters:
- BITS, 8, data bits per frame (excluding ACK bit).
- CNT_W, 8, width of the prescaler / edge-counter inputs.
- LEN_W, 8, width of the burst length and byte counter.
- DRIVE_OFS, 1, edge-counter value (after SCL fall) at which SDA is updated.
- AUTO_NACK, 1, 1 = master drives NACK on the last read byte regardless of ack_bit_i.

Ports:
- i2c_core_clock_i  in  1  core clock.
- reset_bit_n_i  in  1  asynchronous, active-low reset.
- sda_i  in  1  synchronised SDA line.
- start_cnt_i, repeat_start_cnt_i, stop_cnt_i  in  1 each  FSM phase strobes.
- write_addr_cnt_i, write_data_cnt_i, read_data_cnt_i  in  1 each  FSM phase strobes.
- write_ack_cnt_i, read_ack_cnt_i  in  1 each  FSM phase strobes.
- counter_detect_edge_i  in  CNT_W  SCL phase counter.
- prescaler_i  in  CNT_W  half-period count; the SCL-high sample point.
- counter_state_done_time_repeat_start_i  in  CNT_W  repeat-start timer.
- addr_rw_i  in  BITS  address + R/W frame.
- tx_data_i  in  BITS  write byte.
- ack_bit_i  in  1  master ACK value (0 = ACK).
- burst_len_i  in  LEN_W  bytes in burst; 0 is treated as 1.
- arb_clr_i  in  1  clears arb_lost_o.
- sda_o  out  1  SDA drive value (1 = release).
- rx_data_o  out  BITS  last received byte.
- rx_valid_o  out  1  one-cycle pulse, rx_data_o updated.
- tx_req_o  out  1  one-cycle pulse, tx_data_i consumed; next byte wanted.
- bit_cnt_o  out  clog2(BITS+1)  bit index in the current frame.
- byte_cnt_o  out  LEN_W  completed bytes in the burst.
- burst_last_o  out  1  current byte is the last of the burst.
- ack_rcvd_o  out  1  last sampled slave ACK (0 = ACK).
- nack_o  out  1  one-cycle pulse on a sampled NACK.
- arb_lost_o  out  1  sticky arbitration lost.

Behaviour:
- Reset values:
  - sda_o = 1, ack_rcvd_o = 1;
  - all other outputs = 0;
  - shift register = 0.
- Events:
  - drv_evt = (counter_detect_edge_i == DRIVE_OFS);
  - smp_evt = (counter_detect_edge_i == prescaler_i).
- Data phase = any of write_addr, write_data, read_data, write_ack, read_ack.
- Bit counter:
  - increments on smp_evt in a data phase;
  - after the sample at bit_cnt_o == BITS (the ACK bit), wraps to 0 in the same cycle. No extra cycle at 9, unlike the previous generation.
  - Cleared by start/repeat_start.
- SDA drive priority, highest first:
  1. start: 0.
  2. repeat_start: 1 while timer < 2*prescaler_i+1, else 0. Compare in CNT_W+2 bits, no overflow.
  3. stop: 0 on drv_evt; 1 on smp_evt.
  4. write_ack on drv_evt+1: drive ack_bit_i, or 1 if AUTO_NACK and burst_last_o.
  5. read_ack or read_data: 1 (release).
  6. write_addr / write_data on drv_evt: bit [BITS-1-bit_cnt_o] of addr_rw_i / tx_data_i.
  7. Otherwise hold.
- Arbitration loss while arb_lost_o = 1:
  - sda_o is forced to 1 in every phase except start;
  - counters keep running.
- TX handshake: tx_req_o pulses the cycle after the ACK sample of each write_data byte.
- RX path:
  - read_data: on smp_evt, shift in sda_i MSB first.
  - On the sample with bit_cnt_o == BITS-1: rx_data_o <= {shift[BITS-2:0], sda_i}, and rx_valid_o pulses next cycle.
- Slave ACK capture:
  - read_ack: on smp_evt with bit_cnt_o == BITS, ack_rcvd_o <= sda_i.
  - If sda_i == 1, nack_o pulses next cycle.
- Arbitration check:
  - write_addr/write_data: on smp_evt, if sda_o == 1 and sda_i == 0, arb_lost_o <= 1.
  - arb_lost_o is sticky until arb_clr_i or start_cnt_i; clear wins over a simultaneous set.
- Byte counter:
  - byte_cnt_o increments at every ACK-bit sample in a data phase;
  - saturates at all-ones;
  - cleared by start/repeat_start.
  - burst_last_o = (byte_cnt_o + 1 >= max(burst_len_i,1)).
- Simultaneous phase strobes: priority order above applies to SDA and counters. Only the winning phase advances state.
- Reset mid-frame aborts immediately to reset values; no partial rx_valid_o.

Decomposition:
- Shared package i2c_dp_pkg holds:
  - ACK = 0, NACK = 1;
  - default DRIVE_OFS;
  - the bit-counter width function clog2(BITS+1).
- One sub-module, i2c_bit_shifter: parametrised BITS-wide shift/sample register with bit counter. Shared with the planned slave datapath.

Test Plan:
- Write 0xA4 addr then tx_data 0x3C, prescaler 4, ACK=0 from slave:
  - sda_o serialises 1,0,1,0,0,1,0,0 then 0,0,1,1,1,1,0,0, updated at edge count 1;
  - tx_req_o pulses once per byte;
  - ack_rcvd_o = 0, nack_o silent.
- Read burst_len 3, slave sends 0x5A, 0xFF, 0x81:
  - rx_valid_o pulses 3 times with those values;
  - sda_o = 0 on ACK bits 1–2 and 1 on ACK bit 3 (AUTO_NACK), with ack_bit_i = 0.
- Write with slave NACK (sda_i = 1 on ACK bit): ack_rcvd_o = 1, nack_o single pulse, bit_cnt_o wraps to 0.
- Arbitration: during address bit 2, drive sda_o = 1 while sda_i = 0 at sample:
  - arb_lost_o = 1 and sda_o stays 1 for the remaining bits;
  - arb_clr_i clears it.
- Repeat start, prescaler 5: sda_o = 1 for timer 0..10, 0 from 11. Stop: 0 at edge 1, 1 at edge 5.
- Assert reset mid-read at bit 4: all outputs to reset values within the same cycle; no rx_valid_o afterwards.
